// File: rtl/coffee.sv
// -----------------------------------------------------------------------------
// coffee -- coin-operated coffee vending controller
//
// Counts coins (one per clock on C_IN) and pulses COFF for one cycle when the
// credit reaches PRICE. A cancel request on B_IN returns the accumulated credit
// as a train of one-cycle BAL pulses, one pulse per coin.
//
// Parameters:
//   PRICE  coins per cup (1..15)
//   CW     width of the credit and refund counters (2^CW > PRICE)
//
// Ports:
//   CLK    input   rising-edge clock
//   RST    input   synchronous active-high reset
//   C_IN   input   coin present this cycle (level, one coin per sampled cycle)
//   B_IN   input   cancel / refund request
//   COFF   output  registered dispense strobe, one cycle per cup
//   BAL    output  registered coin-return strobe, one cycle per refunded coin
// -----------------------------------------------------------------------------
module coffee #(
    parameter int PRICE = 3,
    parameter int CW    = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic C_IN,
    input  logic B_IN,
    output logic COFF,
    output logic BAL
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        VEND    = 2'd2,
        REFUND  = 2'd3
    } state_t;

    localparam logic [CW-1:0] ZERO    = {CW{1'b0}};
    localparam logic [CW-1:0] ONE     = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] PRICE_C = CW'(PRICE);

    state_t        state_r;
    state_t        state_next_s;
    logic [CW-1:0] credit_r;
    logic [CW-1:0] credit_next_s;
    logic [CW-1:0] credit_sum_s;
    // Holds the number of BAL pulses still owed *after* the one currently
    // on the output, because the first pulse is emitted on the same edge
    // that accepts the cancel request.
    logic [CW-1:0] refund_r;
    logic [CW-1:0] refund_next_s;
    logic          coff_r;
    logic          coff_next_s;
    logic          bal_r;
    logic          bal_next_s;

    // Next-state, next-credit and next-output decode
    always_comb begin
        credit_sum_s  = credit_r + {{(CW-1){1'b0}}, C_IN};
        state_next_s  = state_r;
        credit_next_s = credit_r;
        refund_next_s = refund_r;
        coff_next_s   = 1'b0;
        bal_next_s    = 1'b0;

        case (state_r)
            IDLE, COLLECT, VEND: begin
                if (B_IN && (credit_sum_s != ZERO)) begin
                    // Refund wins over a completing coin; the coin arriving
                    // together with the cancel is part of the refund.
                    bal_next_s    = 1'b1;
                    refund_next_s = credit_sum_s - ONE;
                    credit_next_s = ZERO;
                    state_next_s  = (credit_sum_s == ONE) ? IDLE : REFUND;
                end else if (credit_sum_s == PRICE_C) begin
                    coff_next_s   = 1'b1;
                    credit_next_s = ZERO;
                    state_next_s  = VEND;
                end else begin
                    credit_next_s = credit_sum_s;
                    state_next_s  = (credit_sum_s != ZERO) ? COLLECT : IDLE;
                end
            end
            REFUND: begin
                // Coins and cancel requests are ignored while refunding.
                if (refund_r != ZERO) begin
                    bal_next_s    = 1'b1;
                    refund_next_s = refund_r - ONE;
                    // Leave on the edge that emits the last pulse so the coin
                    // sampled on the following edge is already accepted.
                    state_next_s  = (refund_r == ONE) ? IDLE : REFUND;
                end else begin
                    refund_next_s = ZERO;
                    state_next_s  = IDLE;
                end
            end
            default: begin
                state_next_s  = IDLE;
                credit_next_s = ZERO;
                refund_next_s = ZERO;
            end
        endcase
    end

    // State, counter and output registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r  <= IDLE;
            credit_r <= ZERO;
            refund_r <= ZERO;
            coff_r   <= 1'b0;
            bal_r    <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            credit_r <= credit_next_s;
            refund_r <= refund_next_s;
            coff_r   <= coff_next_s;
            bal_r    <= bal_next_s;
        end
    end

    assign COFF = coff_r;
    assign BAL  = bal_r;

endmodule

// File: tb/tb_coffee.sv
// -----------------------------------------------------------------------------
// tb_coffee -- directed self-checking bench for coffee (PRICE = 3, CW = 4)
//
// Inputs are driven 1 time unit after a rising edge; outputs are checked
// 1 time unit after the edge that samples those inputs.
// -----------------------------------------------------------------------------
module tb_coffee;

    logic CLK;
    logic RST;
    logic C_IN;
    logic B_IN;
    logic COFF;
    logic BAL;

    int checks;
    int errors;

    coffee #(
        .PRICE(3),
        .CW   (4)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .C_IN(C_IN),
        .B_IN(B_IN),
        .COFF(COFF),
        .BAL (BAL)
    );

    // Free-running clock, 10 time-unit period
    always #5 CLK = ~CLK;

    // Apply one cycle of inputs, then check both outputs after the edge
    task automatic cyc(input logic c, input logic b,
                       input logic exp_coff, input logic exp_bal,
                       input string tag);
        C_IN = c;
        B_IN = b;
        @(posedge CLK);
        #1;
        checks++;
        assert (COFF === exp_coff)
        else begin
            errors++;
            $error("FAIL %s COFF observed %0b expected %0b", tag, COFF, exp_coff);
        end
        checks++;
        assert (BAL === exp_bal)
        else begin
            errors++;
            $error("FAIL %s BAL observed %0b expected %0b", tag, BAL, exp_bal);
        end
    endtask

    // Directed stimulus sequence
    initial begin
        checks = 0;
        errors = 0;
        CLK    = 1'b0;
        RST    = 1'b1;
        C_IN   = 1'b1;
        B_IN   = 1'b1;

        // Reset held 2 cycles with coin and cancel asserted
        cyc(1'b1, 1'b1, 1'b0, 1'b0, "rst_0");
        cyc(1'b1, 1'b1, 1'b0, 1'b0, "rst_1");
        RST = 1'b0;
        // 2 coins, then cancel: exactly 2 BAL pulses
        cyc(1'b1, 1'b0, 1'b0, 1'b0, "rst_coin1");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, "rst_coin2");
        cyc(1'b0, 1'b1, 1'b0, 1'b1, "rst_bal1");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, "rst_bal2");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, "rst_bal_end");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, "rst_idle");

        // Three consecutive coins -> one COFF at the third
        cyc(1'b1, 1'b0, 1'b0, 1'b0, "vend_c1");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, "vend_c2");
        cyc(1'b1, 1'b0, 1'b1, 1'b0, "vend_c3");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, "vend_after");

        // Pattern 1,0,1,1 -> COFF after the 4th sample only
        cyc(1'b1, 1'b0, 1'b0, 1'b0, "gap_s1");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, "gap_s2");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, "gap_s3");
        cyc(1'b1, 1'b0, 1'b1, 1'b0, "gap_s4");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, "gap_after1");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, "gap_after2");

        // Six coins -> two COFF pulses three cycles apart
        cyc(1'b1, 1'b0, 1'b0, 1'b0, "b2b_c1");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, "b2b_c2");
        cyc(1'b1, 1'b0, 1'b1, 1'b0, "b2b_c3");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, "b2b_c4");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, "b2b_c5");
        cyc(1'b1, 1'b0, 1'b1, 1'b0, "b2b_c6");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, "b2b_after");

        // Refund of 2 coins; a coin offered during the refund is not credited
        cyc(1'b1, 1'b0, 1'b0, 1'b0, "ref_c1");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, "ref_c2");
        cyc(1'b0, 1'b1, 1'b0, 1'b1, "ref_bal1");
        cyc(1'b1, 1'b0, 1'b0, 1'b1, "ref_bal2_coin_ignored");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, "ref_new_c1");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, "ref_new_c2");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, "ref_no_vend");

        // Credit is 2: completing coin with cancel -> 3 BAL, no COFF
        cyc(1'b1, 1'b1, 1'b0, 1'b1, "sim_bal1");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, "sim_bal2");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, "sim_bal3");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, "sim_end");

        // Cancel with no credit is ignored
        cyc(1'b0, 1'b1, 1'b0, 1'b0, "cancel_empty");

        // Reset after the first BAL pulse aborts the refund
        cyc(1'b1, 1'b0, 1'b0, 1'b0, "abort_c1");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, "abort_c2");
        cyc(1'b0, 1'b1, 1'b0, 1'b1, "abort_bal1");
        RST = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, "abort_rst");
        RST = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, "abort_quiet");
        // Credit was cleared: one coin plus cancel -> exactly one BAL pulse
        cyc(1'b1, 1'b1, 1'b0, 1'b1, "abort_one_bal");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, "abort_one_end");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, "abort_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
